// File: rtl/map_layer_scheduler.sv
`timescale 1ns/1ps
// map_layer_scheduler
//   Drives the block_generator and captures each generated layer (layer_map + block_type)
//   into a DEPTH-row ring buffer. The game/render side reads rows by logical index
//   (0 = oldest/bottom) and requests one-layer scrolls.
//
// Ports
//   clk, rst           system clock, asynchronous active-high reset
//   start              pulse: build the initial map (only acted on while idle)
//   scroll_req         pulse: drop the bottom row, append a fresh top row (only while ready)
//   scroll_ack         1-cycle pulse after the new top row has been written
//   busy               high in S_INIT, S_FILL, S_SCROLL
//   map_valid          high in S_READY
//   error              high once a timeout or protocol error occurred (held until rst)
//   gen_generate       1-cycle request pulse to block_generator.generate_map
//   gen_layer_map      layer bitmap from the generator, bit order [0:6]
//   gen_block_type     block types from the generator, bit order [0:6]
//   gen_load_layer     generator strobe: layer data valid this cycle
//   gen_map_ready      generator flag: initial map complete (must accompany 4th init load)
//   rd_row             logical row to read
//   rd_layer_map       registered row data, 1-cycle latency
//   rd_block_type      registered row data, 1-cycle latency
//
// Handshake: gen_generate is a single-cycle request; the generator answers with one
// gen_load_layer strobe per layer (four strobes after the initial request). A strobe is
// accepted only in a state that is waiting for one; all other strobes are ignored.
module map_layer_scheduler #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          scroll_req,
  output logic          scroll_ack,
  output logic          busy,
  output logic          map_valid,
  output logic          error,
  output logic          gen_generate,
  input  logic [0:6]    gen_layer_map,
  input  logic [0:6]    gen_block_type,
  input  logic          gen_load_layer,
  input  logic          gen_map_ready,
  input  logic [AW-1:0] rd_row,
  output logic [0:6]    rd_layer_map,
  output logic [0:6]    rd_block_type
);

  localparam int          TW        = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] ROWS_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ROWS_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FILL, S_READY, S_SCROLL, S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   base_q, wr_ptr_q;
  logic [AW:0]     rows_q;
  logic [1:0]      init_cnt_q;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            scroll_ack_q;
  logic [13:0]     rd_q;
  logic [13:0]     mem [DEPTH];
  logic [AW-1:0]   rd_addr;

  logic            wr_en;
  logic            base_inc;
  logic            ack_d;
  logic            waiting;

  // Next-state and request logic. gen_generate is a Mealy output so the request leaves
  // in the same cycle as the triggering start/scroll_req/load.
  always_comb begin
    state_d      = state_q;
    gen_generate = 1'b0;
    wr_en        = 1'b0;
    base_inc     = 1'b0;
    ack_d        = 1'b0;
    waiting      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_INIT;
          gen_generate = 1'b1;
        end
      end
      S_INIT: begin
        waiting = 1'b1;
        if (gen_load_layer) begin
          if (init_cnt_q == 2'd3) begin
            if (!gen_map_ready) begin
              state_d = S_ERROR;
            end else begin
              wr_en = 1'b1;
              if (DEPTH > 4) begin
                state_d      = S_FILL;
                gen_generate = 1'b1;
              end else begin
                state_d = S_READY;
              end
            end
          end else if (gen_map_ready) begin
            state_d = S_ERROR;
          end else begin
            wr_en = 1'b1;
          end
        end
      end
      S_FILL: begin
        waiting = 1'b1;
        if (gen_load_layer) begin
          wr_en = 1'b1;
          if (rows_q == ROWS_LAST) state_d = S_READY;
          else gen_generate = 1'b1;
        end
      end
      S_READY: begin
        if (scroll_req) begin
          state_d      = S_SCROLL;
          gen_generate = 1'b1;
        end
      end
      S_SCROLL: begin
        waiting = 1'b1;
        if (gen_load_layer) begin
          wr_en    = 1'b1;
          base_inc = 1'b1;
          ack_d    = 1'b1;
          state_d  = S_READY;
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase
    // A load arriving in the last allowed cycle still wins over the timeout.
    if (waiting && !gen_load_layer && (tmo_q >= TMO_LAST)) begin
      state_d  = S_ERROR;
      wr_en    = 1'b0;
      base_inc = 1'b0;
      ack_d    = 1'b0;
    end
  end

  // tmo_q counts cycles since the last request/accepted load, with that event cycle
  // itself counted as 1, so the error becomes visible TIMEOUT cycles after a request.
  always_comb begin
    tmo_d = '0;
    if (gen_generate || wr_en) tmo_d = TW'(1);
    else if (waiting)          tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      wr_ptr_q     <= '0;
      rows_q       <= '0;
      init_cnt_q   <= '0;
      tmo_q        <= '0;
      scroll_ack_q <= 1'b0;
      rd_q         <= '0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      scroll_ack_q <= ack_d;
      rd_q         <= mem[rd_addr];
      if (state_q == S_IDLE && start) init_cnt_q <= '0;
      else if (state_q == S_INIT && wr_en) init_cnt_q <= init_cnt_q + 1'b1;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (rows_q != ROWS_FULL) rows_q <= rows_q + 1'b1;
      end
      if (base_inc) base_q <= base_q + 1'b1;
    end
  end

  // Storage has no reset; reads in the write cycle see the previous contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {gen_layer_map, gen_block_type};
  end

  assign rd_addr       = base_q + rd_row;
  assign rd_layer_map  = rd_q[13:7];
  assign rd_block_type = rd_q[6:0];
  assign scroll_ack    = scroll_ack_q;
  assign busy          = (state_q == S_INIT) || (state_q == S_FILL) || (state_q == S_SCROLL);
  assign map_valid     = (state_q == S_READY);
  assign error         = (state_q == S_ERROR);

endmodule

// File: tb/tb_map_layer_scheduler.sv
`timescale 1ns/1ps
module tb_map_layer_scheduler;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 15;
  localparam int AW      = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          scroll_req;
  logic          scroll_ack;
  logic          busy;
  logic          map_valid;
  logic          error;
  logic          gen_generate;
  logic [0:6]    gen_layer_map;
  logic [0:6]    gen_block_type;
  logic          gen_load_layer;
  logic          gen_map_ready;
  logic [AW-1:0] rd_row;
  logic [0:6]    rd_layer_map;
  logic [0:6]    rd_block_type;

  int n_checks = 0;
  int n_errors = 0;

  logic [13:0] exp_q[$];       // expected read data, pushed when rd_row is driven
  logic [13:0] model[$];       // logical rows, bottom first
  logic [13:0] gen_data_q[$];  // layers the generator model will emit

  int gen_mode = 0;            // 0 normal, 1 silent, 2 map_ready on 2nd init load
  bit init_pend = 0;
  int gen_count = 0;

  map_layer_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .scroll_req(scroll_req),
    .scroll_ack(scroll_ack), .busy(busy), .map_valid(map_valid), .error(error),
    .gen_generate(gen_generate), .gen_layer_map(gen_layer_map),
    .gen_block_type(gen_block_type), .gen_load_layer(gen_load_layer),
    .gen_map_ready(gen_map_ready), .rd_row(rd_row),
    .rd_layer_map(rd_layer_map), .rd_block_type(rd_block_type)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (gen_generate === 1'b1) gen_count++;

  // Generator model: sees a request mid-cycle, answers with the first load 3 cycles later
  // (four consecutive loads for the initial request, one otherwise).
  initial begin : gen_model
    int nloads, wait_c, burst_idx;
    bit seen, burst4;
    logic [13:0] d;
    nloads = 0; wait_c = 0; burst_idx = 0; burst4 = 0;
    gen_load_layer = 1'b0; gen_map_ready = 1'b0;
    gen_layer_map = '0; gen_block_type = '0;
    forever begin
      @(negedge clk);
      seen = (gen_generate === 1'b1);
      @(posedge clk); #1;
      gen_load_layer = 1'b0;
      gen_map_ready  = 1'b0;
      if (rst) begin
        nloads = 0;
      end else begin
        if (nloads > 0) begin
          if (wait_c > 0) begin
            wait_c--;
          end else begin
            d = (gen_data_q.size() > 0) ? gen_data_q.pop_front() : 14'h3fff;
            {gen_layer_map, gen_block_type} = d;
            gen_load_layer = 1'b1;
            burst_idx++;
            if (gen_mode == 2) gen_map_ready = burst4 && (burst_idx == 2);
            else               gen_map_ready = burst4 && (burst_idx == 4);
            nloads--;
          end
        end
        if (seen && gen_mode != 1) begin
          nloads    = init_pend ? 4 : 1;
          burst4    = init_pend;
          init_pend = 0;
          wait_c    = 1;
          burst_idx = 0;
        end
      end
    end
  end

  // driver tasks: every task starts and ends 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; scroll_req = 1'b0; init_pend = 0;
    tick(); tick();
    rst = 1'b0;
    gen_data_q.delete();
    model.delete();
  endtask

  task automatic read_row(input int r);
    logic [13:0] got;
    rd_row = AW'(r);
    exp_q.push_back(model[r]);
    @(negedge clk);
    @(negedge clk);
    got = {rd_layer_map, rd_block_type};
    chk($sformatf("rd_row%0d", r), 32'(got), 32'(exp_q.pop_front()));
    tick();
  endtask

  task automatic do_init();
    logic [13:0] pat [4];
    logic [13:0] d;
    int g0;
    bit done;
    pat[0] = {7'b0001000, 7'b0000001};
    pat[1] = {7'b1010101, 7'b0000010};
    pat[2] = {7'b0101010, 7'b0000100};
    pat[3] = {7'b1010101, 7'b0001000};
    model.delete();
    for (int i = 0; i < DEPTH; i++) begin
      d = (i < 4) ? pat[i] : 14'($urandom_range(0, 16383));
      gen_data_q.push_back(d);
      model.push_back(d);
    end
    g0 = gen_count;
    init_pend = 1;
    start = 1'b1;
    @(negedge clk);
    chk("init_gen", 32'(gen_generate), 1);
    tick();
    start = 1'b0;
    done = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (map_valid === 1'b1) begin done = 1; break; end
      tick();
    end
    chk("init_map_valid", 32'(done), 1);
    chk("init_gen_pulses", 32'(gen_count - g0), 32'(DEPTH - 3));
    chk("init_busy", 32'(busy), 0);
    tick();
  endtask

  task automatic do_scroll(input bit extra, output int lat);
    logic [13:0] d;
    int g0;
    d = 14'($urandom_range(0, 16383));
    gen_data_q.push_back(d);
    void'(model.pop_front());
    model.push_back(d);
    g0 = gen_count;
    scroll_req = 1'b1;
    @(negedge clk);
    chk("scroll_gen", 32'(gen_generate), 1);
    tick();
    scroll_req = extra;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      if (k == 2) scroll_req = 1'b0;
      @(negedge clk);
      if (scroll_ack === 1'b1) begin lat = k; break; end
      tick();
    end
    scroll_req = 1'b0;
    tick();
    @(negedge clk);
    chk("scroll_ack_width", 32'(scroll_ack), 0);
    chk("scroll_gen_pulses", 32'(gen_count - g0), 1);
    tick();
  endtask

  initial begin : main
    int lat, g0;
    bit saw_valid;
    rst = 1'b1; start = 1'b0; scroll_req = 1'b0; rd_row = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_scroll_ack", 32'(scroll_ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_map_valid", 32'(map_valid), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_gen_generate", 32'(gen_generate), 0);
    chk("rst_rd", 32'({rd_layer_map, rd_block_type}), 0);
    tick();
    rst = 1'b0;
    tick();

    // initial map build, all rows read back in order
    do_init();
    for (int r = 0; r < DEPTH; r++) read_row(r);

    // first scroll: latency, shifted rows
    do_scroll(0, lat);
    chk("scroll_latency", 32'(lat), 4);
    read_row(0);
    read_row(DEPTH - 1);

    // eight more scrolls (nine total, base wraps), one with a stray scroll_req mid-scroll
    for (int i = 0; i < 8; i++) begin
      do_scroll(i == 3, lat);
      chk("scroll_latency_b2b", 32'(lat), 4);
    end
    for (int r = 0; r < DEPTH; r++) read_row(r);

    // async reset in the middle of init, then a clean re-init
    init_pend = 1;
    for (int i = 0; i < 4; i++) gen_data_q.push_back(14'($urandom_range(0, 16383)));
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_map_valid", 32'(map_valid), 0);
    chk("arst_gen", 32'(gen_generate), 0);
    chk("arst_rd", 32'({rd_layer_map, rd_block_type}), 0);
    tick(); tick();
    rst = 1'b0;
    init_pend = 0;
    gen_data_q.delete();
    tick();
    do_init();
    for (int r = 0; r < 4; r++) read_row(r);

    // map_ready together with the 2nd init load
    gen_mode = 2;
    do_reset();
    for (int i = 0; i < 4; i++) gen_data_q.push_back(14'($urandom_range(0, 16383)));
    init_pend = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    saw_valid = 0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (map_valid === 1'b1) saw_valid = 1;
      if (error === 1'b1) begin lat = k; break; end
      tick();
    end
    chk("early_ready_error_seen", 32'(lat > 0), 1);
    chk("early_ready_no_valid", 32'(saw_valid), 0);
    chk("early_ready_busy", 32'(busy), 0);
    tick();

    // silent generator: timeout, then dead until reset
    gen_mode = 1;
    do_reset();
    init_pend = 1;
    start = 1'b1;
    @(negedge clk);
    chk("silent_gen", 32'(gen_generate), 1);
    tick();
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (error === 1'b1) begin lat = k; break; end
      tick();
    end
    chk("timeout_cycle", 32'(lat), 32'(TIMEOUT));
    tick();
    g0 = gen_count;
    start = 1'b1;
    scroll_req = 1'b1;
    @(negedge clk);
    chk("error_no_gen", 32'(gen_generate), 0);
    tick();
    start = 1'b0;
    scroll_req = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("error_gen_pulses", 32'(gen_count - g0), 0);
    chk("error_sticky", 32'(error), 1);
    chk("error_map_valid", 32'(map_valid), 0);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
